// File: rtl/vend_controller_param.sv
// rtl/vend_controller_param.sv - parametrised vending transaction controller
//
// Purpose: accumulates coin credit, runs the purchase FSM, tracks per-slot
// stock with restock, forces a refund after an idle timeout, and pays change
// back one coin per cycle using the largest denomination that fits.
//
// Ports:
//   CLK, RESET                     clock, asynchronous active-high reset
//   coin_valid, coin_code          coin strobe and denomination (5/10/20/50)
//   sel_valid, sel_id              product selection strobe and slot
//   cancel                         refund request
//   restock_valid, restock_id, restock_qty   restock strobe, slot, units
//   credit, state                  current credit and FSM state
//   vend_valid, vend_id            dispense pulse and slot
//   change_valid, change_code      one change coin per cycle
//   low_stock_mask, empty_mask     per-slot stock flags
//   err_funds, err_stock, err_select, coin_reject   one-cycle error pulses
module vend_controller_param #(
  parameter int NUM_PRODUCTS   = 8,
  parameter int STOCK_W        = 5,
  parameter int INIT_STOCK     = 10,
  parameter int CREDIT_W       = 16,
  parameter int MAX_CREDIT     = 500,
  parameter int PRICE_BASE     = 10,
  parameter int PRICE_STEP     = 5,
  parameter int LOW_THRESHOLD  = 5,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    coin_valid,
  input  logic [1:0]              coin_code,
  input  logic                    sel_valid,
  input  logic [ID_W-1:0]         sel_id,
  input  logic                    cancel,
  input  logic                    restock_valid,
  input  logic [ID_W-1:0]         restock_id,
  input  logic [STOCK_W-1:0]      restock_qty,
  output logic [CREDIT_W-1:0]     credit,
  output logic [1:0]              state,
  output logic                    vend_valid,
  output logic [ID_W-1:0]         vend_id,
  output logic                    change_valid,
  output logic [1:0]              change_code,
  output logic [NUM_PRODUCTS-1:0] low_stock_mask,
  output logic [NUM_PRODUCTS-1:0] empty_mask,
  output logic                    err_funds,
  output logic                    err_stock,
  output logic                    err_select,
  output logic                    coin_reject
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_W:0] MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [STOCK_W:0]  STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};
  localparam logic [STOCK_W:0]  LOW_T     = (STOCK_W + 1)'(LOW_THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    return CREDIT_W'(5);
      2'd1:    return CREDIT_W'(10);
      2'd2:    return CREDIT_W'(20);
      default: return CREDIT_W'(50);
    endcase
  endfunction

  // Largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] change_denom(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(50))      return 2'd3;
    else if (c >= CREDIT_W'(20)) return 2'd2;
    else if (c >= CREDIT_W'(10)) return 2'd1;
    else                         return 2'd0;
  endfunction

  state_t                 state_q, state_d;
  logic [CREDIT_W-1:0]    credit_q, credit_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [STOCK_W-1:0]     stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0]     stock_d [NUM_PRODUCTS];
  logic                   vend_valid_q, vend_valid_d;
  logic [ID_W-1:0]        vend_id_q, vend_id_d;
  logic                   change_valid_q, change_valid_d;
  logic [1:0]             change_code_q, change_code_d;
  logic                   err_funds_q, err_funds_d;
  logic                   err_stock_q, err_stock_d;
  logic                   err_select_q, err_select_d;
  logic                   coin_reject_q, coin_reject_d;

  logic                   vend_take;
  logic [CREDIT_W-1:0]    coin_val, price, chg_val;
  logic [CREDIT_W:0]      coin_sum;
  logic [1:0]             chg_code;
  logic                   sel_in_range;
  logic [STOCK_W:0]       stk_tmp;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = '0;
    vend_valid_d   = 1'b0;
    vend_id_d      = vend_id_q;
    change_valid_d = 1'b0;
    change_code_d  = '0;
    err_funds_d    = 1'b0;
    err_stock_d    = 1'b0;
    err_select_d   = 1'b0;
    coin_reject_d  = 1'b0;
    vend_take      = 1'b0;
    coin_val       = coin_value(coin_code);
    coin_sum       = {1'b0, credit_q} + {1'b0, coin_val};
    price          = CREDIT_W'(PRICE_BASE + PRICE_STEP * int'(sel_id));
    sel_in_range   = 32'(sel_id) < NUM_PRODUCTS;
    chg_code       = change_denom(credit_q);
    chg_val        = coin_value(chg_code);

    case (state_q)
      S_IDLE: begin
        if (coin_valid) begin
          if ({1'b0, coin_val} > MAX_C) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_val;
            state_d  = S_CREDIT;
          end
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = S_CHANGE;
        end else if (sel_valid) begin
          // A selection attempt of any outcome restarts the idle timer.
          coin_reject_d = coin_valid;
          if (!sel_in_range) begin
            err_select_d = 1'b1;
          end else if (stock_q[sel_id] == '0) begin
            err_stock_d = 1'b1;
          end else if (credit_q < price) begin
            err_funds_d = 1'b1;
          end else begin
            credit_d     = credit_q - price;
            vend_take    = 1'b1;
            vend_id_d    = sel_id;
            vend_valid_d = 1'b1;
            state_d      = S_VEND;
          end
        end else if (coin_valid && coin_sum <= MAX_C) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end else begin
          coin_reject_d = coin_valid;
          if (timer_q == TMR_LAST) begin
            state_d = S_CHANGE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end

      S_VEND: begin
        coin_reject_d = coin_valid;
        state_d       = (credit_q == '0) ? S_IDLE : S_CHANGE;
      end

      default: begin
        coin_reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else begin
          change_valid_d = 1'b1;
          change_code_d  = chg_code;
          credit_d       = credit_q - chg_val;
        end
      end
    endcase
  end

  // Vend decrement and restock of the same slot combine before saturation.
  always_comb begin
    stk_tmp = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stk_tmp = {1'b0, stock_q[i]};
      if (vend_take && 32'(sel_id) == i)
        stk_tmp = stk_tmp - (STOCK_W + 1)'(1);
      if (restock_valid && 32'(restock_id) == i)
        stk_tmp = stk_tmp + {1'b0, restock_qty};
      if (stk_tmp > STOCK_MAX)
        stk_tmp = STOCK_MAX;
      stock_d[i] = stk_tmp[STOCK_W-1:0];
    end
  end

  always_comb begin
    low_stock_mask = '0;
    empty_mask     = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      low_stock_mask[i] = {1'b0, stock_q[i]} < LOW_T;
      empty_mask[i]     = stock_q[i] == '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      vend_valid_q   <= 1'b0;
      vend_id_q      <= '0;
      change_valid_q <= 1'b0;
      change_code_q  <= '0;
      err_funds_q    <= 1'b0;
      err_stock_q    <= 1'b0;
      err_select_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      vend_valid_q   <= vend_valid_d;
      vend_id_q      <= vend_id_d;
      change_valid_q <= change_valid_d;
      change_code_q  <= change_code_d;
      err_funds_q    <= err_funds_d;
      err_stock_q    <= err_stock_d;
      err_select_q   <= err_select_d;
      coin_reject_q  <= coin_reject_d;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock_q[i] <= stock_d[i];
    end
  end

  assign credit       = credit_q;
  assign state        = state_q;
  assign vend_valid   = vend_valid_q;
  assign vend_id      = vend_id_q;
  assign change_valid = change_valid_q;
  assign change_code  = change_code_q;
  assign err_funds    = err_funds_q;
  assign err_stock    = err_stock_q;
  assign err_select   = err_select_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_controller_param.sv
// tb/tb_vend_controller_param.sv - self-checking bench for vend_controller_param
module tb_vend_controller_param;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        coin_valid, sel_valid, cancel, restock_valid;
  logic [1:0]  coin_code;
  logic [2:0]  sel_id, restock_id;
  logic [4:0]  restock_qty;
  logic [15:0] credit;
  logic [1:0]  state;
  logic        vend_valid, change_valid;
  logic [2:0]  vend_id;
  logic [1:0]  change_code;
  logic [7:0]  low_stock_mask, empty_mask;
  logic        err_funds, err_stock, err_select, coin_reject;

  int n_chk = 0;
  int n_fail = 0;

  vend_controller_param dut (
    .CLK(CLK), .RESET(RESET),
    .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .restock_valid(restock_valid), .restock_id(restock_id), .restock_qty(restock_qty),
    .credit(credit), .state(state),
    .vend_valid(vend_valid), .vend_id(vend_id),
    .change_valid(change_valid), .change_code(change_code),
    .low_stock_mask(low_stock_mask), .empty_mask(empty_mask),
    .err_funds(err_funds), .err_stock(err_stock),
    .err_select(err_select), .coin_reject(coin_reject)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       cv;
    logic [1:0] cc;
    logic       sv;
    logic [2:0] sid;
    logic       cn;
    logic [1:0] st;
    logic [15:0] cr;
    logic       vv;
    logic [2:0] vid;
    logic       chv;
    logic [1:0] chc;
    logic [3:0] err;   // {funds, stock, select, reject}
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(int cv, int cc, int sv, int sid, int cn,
                              int st, int cr, int vv, int vid, int chv, int chc, int err);
    vec_t v;
    v.cv = cv[0]; v.cc = cc[1:0]; v.sv = sv[0]; v.sid = sid[2:0]; v.cn = cn[0];
    v.st = st[1:0]; v.cr = cr[15:0]; v.vv = vv[0]; v.vid = vid[2:0];
    v.chv = chv[0]; v.chc = chc[1:0]; v.err = err[3:0];
    return v;
  endfunction

  function automatic logic [31:0] pack_out();
    return 32'({state, credit, vend_valid, vend_id, change_valid, change_code,
                err_funds, err_stock, err_select, coin_reject});
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return 32'({v.st, v.cr, v.vv, v.vid, v.chv, v.chc, v.err});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 0; coin_code = 0; sel_valid = 0; sel_id = 0; cancel = 0;
    restock_valid = 0; restock_id = 0; restock_qty = 0;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1; coin_code = code;
    tick();
    coin_valid = 0;
  endtask

  // Buy a product costing exactly one coin of the given code.
  task automatic buy(input logic [2:0] id, input logic [1:0] code);
    coin(code);
    sel_valid = 1; sel_id = id;
    tick();
    sel_valid = 0;
    chk("buy_vend", 32'({vend_valid, vend_id, state}), 32'({1'b1, id, 2'd2}));
    tick();
  endtask

  int exp_stk;
  int n_coins;
  logic saw_change;

  initial begin
    idle_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;

    // reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_empty", 32'(empty_mask), 32'h00);
    chk("rst_low", 32'(low_stock_mask), 32'h00);
    chk("rst_pulses", 32'({vend_valid, change_valid, err_funds, err_stock, err_select, coin_reject}), 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_stock", 32'(dut.stock_q[i]), 32'd10);

    //           cv cc sv sid cn  st  cr vv vid chv chc err
    vecs[0]  = mk(1, 0, 0, 0, 0,  1,  5, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,  1, 10, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0,  1, 20, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 0,  2,  5, 1, 1, 0, 0, 0);
    vecs[4]  = mk(1, 3, 0, 0, 0,  3,  5, 0, 1, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0,  3,  0, 0, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 0,  1, 10, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 3, 0,  1, 10, 0, 1, 0, 0, 8);
    vecs[9]  = mk(0, 0, 0, 0, 0,  1, 10, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,  3, 10, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0,  3,  0, 0, 1, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0);
    vecs[13] = mk(1, 2, 0, 0, 0,  1, 20, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1,  3, 20, 0, 1, 0, 0, 0);
    vecs[15] = mk(1, 3, 0, 0, 0,  3,  0, 0, 1, 1, 2, 1);
    vecs[16] = mk(0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 0,  1, 10, 0, 1, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 0, 0,  2,  0, 1, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 0, 1,  0,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      coin_valid = vecs[i].cv; coin_code = vecs[i].cc;
      sel_valid = vecs[i].sv; sel_id = vecs[i].sid; cancel = vecs[i].cn;
      tick();
      chk($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end
    idle_inputs();

    // inactivity timeout with credit 70
    coin(2'd3);
    coin(2'd2);
    repeat (63) tick();
    chk("tmo_before", 32'({state, credit}), 32'({2'd1, 16'd70}));
    tick();
    chk("tmo_fire", 32'({state, credit}), 32'({2'd3, 16'd70}));
    tick();
    chk("tmo_chg50", 32'({change_valid, change_code, credit}), 32'({1'b1, 2'd3, 16'd20}));
    tick();
    chk("tmo_chg20", 32'({change_valid, change_code, credit}), 32'({1'b1, 2'd2, 16'd0}));
    tick();
    chk("tmo_idle", 32'({state, change_valid}), 32'd0);

    // stock depletion of product 2 (price 20)
    exp_stk = 10;
    for (int n = 1; n <= 10; n++) begin
      buy(3'd2, 2'd2);
      exp_stk--;
      chk($sformatf("low2_after%0d", n), 32'(low_stock_mask[2]), 32'(exp_stk < 5));
      chk($sformatf("empty2_after%0d", n), 32'(empty_mask[2]), 32'(exp_stk == 0));
    end
    coin(2'd2);
    sel_valid = 1; sel_id = 3'd2;
    tick();
    sel_valid = 0;
    chk("err_stock", 32'({err_stock, err_funds, state, credit}), 32'({1'b1, 1'b0, 2'd1, 16'd20}));
    cancel = 1;
    tick();
    cancel = 0;
    repeat (2) tick();
    chk("drain_idle", 32'({state, credit}), 32'd0);
    restock_valid = 1; restock_id = 3'd2; restock_qty = 5'd30;
    tick();
    chk("restock30", 32'(dut.stock_q[2]), 32'd30);
    chk("restock_masks", 32'({low_stock_mask[2], empty_mask[2]}), 32'd0);
    tick();
    restock_valid = 0;
    chk("restock_sat", 32'(dut.stock_q[2]), 32'd31);

    // vend and restock of the same slot in one cycle: 10 - 1 + 2
    coin(2'd2);
    coin(2'd0);
    sel_valid = 1; sel_id = 3'd3;
    restock_valid = 1; restock_id = 3'd3; restock_qty = 5'd2;
    tick();
    idle_inputs();
    chk("vend_restock", 32'(dut.stock_q[3]), 32'd11);
    tick();

    // credit ceiling: 490 + 50 rejected, 490 + 10 accepted
    for (int i = 0; i < 9; i++) coin(2'd3);
    coin(2'd2);
    coin(2'd2);
    chk("credit490", 32'({state, credit}), 32'({2'd1, 16'd490}));
    coin(2'd3);
    chk("over_max", 32'({coin_reject, credit}), 32'({1'b1, 16'd490}));
    coin(2'd1);
    chk("at_max", 32'({coin_reject, credit}), 32'({1'b0, 16'd500}));
    cancel = 1;
    tick();
    cancel = 0;
    n_coins = 0;
    for (int i = 0; i < 30 && state != 2'd0; i++) begin
      tick();
      if (change_valid && change_code == 2'd3) n_coins++;
    end
    chk("refund500", 32'({state, credit, 8'(n_coins)}), 32'({2'd0, 16'd0, 8'd10}));

    // reset while in VEND
    coin(2'd2);
    sel_valid = 1; sel_id = 3'd1;
    tick();
    sel_valid = 0;
    chk("pre_rst_vend", 32'(state), 32'd2);
    #2 RESET = 1;
    #1;
    chk("rst_in_vend", 32'({state, credit, vend_valid}), 32'd0);
    tick();
    RESET = 0;
    saw_change = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (change_valid || state != 2'd0) saw_change = 1;
    end
    chk("rst_no_change", 32'(saw_change), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
